// File: rtl/freq_duty_meas.sv
// Gated frequency / duty-cycle meter with signal-loss timeout; results and irq appear 1 cycle after the closing edge.
// No backpressure: irq and timeout are single-cycle pulses and cnt_* hold until the next gate closes or the signal is lost.
module freq_duty_meas #(
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned TIMEOUT   = 200_000_000
) (
   input  logic                 clk_100M,
   input  logic                 rst_n,
   input  logic                 meas_rst,
   input  logic                 sig,
   input  logic [CNT_WIDTH-1:0] gate_len,
   output logic [CNT_WIDTH-1:0] cnt_s,
   output logic [CNT_WIDTH-1:0] cnt_x,
   output logic [CNT_WIDTH-1:0] cnt_h,
   output logic                 irq,
   output logic                 timeout,
   output logic                 valid
);

   typedef enum logic {ARM = 1'b0, GATE = 1'b1} state_t;

   localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic                 sig_prev_q, sig_prev_d;
   logic [CNT_WIDTH-1:0] idle_q, idle_d;
   logic [CNT_WIDTH-1:0] run_s_q, run_s_d;
   logic [CNT_WIDTH-1:0] run_x_q, run_x_d;
   logic [CNT_WIDTH-1:0] run_h_q, run_h_d;
   logic [CNT_WIDTH-1:0] gl_q, gl_d;
   logic [CNT_WIDTH-1:0] cnt_s_q, cnt_s_d;
   logic [CNT_WIDTH-1:0] cnt_x_q, cnt_x_d;
   logic [CNT_WIDTH-1:0] cnt_h_q, cnt_h_d;
   logic                 irq_q, irq_d;
   logic                 timeout_q, timeout_d;
   logic                 valid_q, valid_d;

   logic                 sig_rise;
   logic                 idle_exp;
   logic                 gate_close;
   logic [CNT_WIDTH-1:0] gl_new;

   always_comb begin
      sig_rise   = sig & ~sig_prev_q;
      // an edge landing on the expiry cycle keeps the measurement alive
      idle_exp   = (idle_q == IDLE_LAST) & ~sig_rise;
      gate_close = (state_q == GATE) & sig_rise & (run_s_q >= gl_q);
      gl_new     = (gate_len == '0) ? ONE : gate_len;

      state_d    = state_q;
      sig_prev_d = sig;
      idle_d     = sig_rise ? '0 : idle_q + ONE;
      run_s_d    = run_s_q;
      run_x_d    = run_x_q;
      run_h_d    = run_h_q;
      gl_d       = gl_q;
      cnt_s_d    = cnt_s_q;
      cnt_x_d    = cnt_x_q;
      cnt_h_d    = cnt_h_q;
      valid_d    = valid_q;
      irq_d      = 1'b0;
      timeout_d  = 1'b0;

      if (meas_rst) begin
         state_d = ARM;
         run_s_d = '0;
         run_x_d = '0;
         run_h_d = '0;
         idle_d  = '0;
      end else if (sig_rise && ((state_q == ARM) || gate_close)) begin
         if (gate_close) begin
            cnt_s_d = run_s_q;
            cnt_x_d = run_x_q + ONE;
            cnt_h_d = run_h_q;
            irq_d   = 1'b1;
            valid_d = 1'b1;
         end
         // the closing edge is also the opening edge of the next gate
         state_d = GATE;
         run_s_d = ONE;
         run_x_d = '0;
         run_h_d = ONE;
         gl_d    = gl_new;
      end else if (idle_exp) begin
         state_d   = ARM;
         run_s_d   = '0;
         run_x_d   = '0;
         run_h_d   = '0;
         idle_d    = '0;
         cnt_s_d   = '0;
         cnt_x_d   = '0;
         cnt_h_d   = '0;
         valid_d   = 1'b0;
         timeout_d = 1'b1;
      end else if (state_q == GATE) begin
         run_s_d = run_s_q + ONE;
         run_x_d = run_x_q + {{(CNT_WIDTH-1){1'b0}}, sig_rise};
         run_h_d = run_h_q + {{(CNT_WIDTH-1){1'b0}}, sig};
      end
   end

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARM;
         sig_prev_q <= 1'b0;
         idle_q     <= '0;
         run_s_q    <= '0;
         run_x_q    <= '0;
         run_h_q    <= '0;
         gl_q       <= '0;
         cnt_s_q    <= '0;
         cnt_x_q    <= '0;
         cnt_h_q    <= '0;
         irq_q      <= 1'b0;
         timeout_q  <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sig_prev_q <= sig_prev_d;
         idle_q     <= idle_d;
         run_s_q    <= run_s_d;
         run_x_q    <= run_x_d;
         run_h_q    <= run_h_d;
         gl_q       <= gl_d;
         cnt_s_q    <= cnt_s_d;
         cnt_x_q    <= cnt_x_d;
         cnt_h_q    <= cnt_h_d;
         irq_q      <= irq_d;
         timeout_q  <= timeout_d;
         valid_q    <= valid_d;
      end
   end

   assign cnt_s   = cnt_s_q;
   assign cnt_x   = cnt_x_q;
   assign cnt_h   = cnt_h_q;
   assign irq     = irq_q;
   assign timeout = timeout_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_freq_duty_meas.sv
// Bench for freq_duty_meas: directed period/duty scenarios plus randomized traffic against a gate-history model.
module tb_freq_duty_meas;

   localparam int CW = 32;
   localparam int TO = 1000;

   logic          clk_100M = 1'b0;
   logic          rst_n    = 1'b0;
   logic          meas_rst = 1'b0;
   logic          sig      = 1'b0;
   logic [CW-1:0] gate_len = '0;
   logic [CW-1:0] cnt_s, cnt_x, cnt_h;
   logic          irq, timeout, valid;
   logic [3*CW+2:0] dut_vec;

   freq_duty_meas #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
      .clk_100M (clk_100M),
      .rst_n    (rst_n),
      .meas_rst (meas_rst),
      .sig      (sig),
      .gate_len (gate_len),
      .cnt_s    (cnt_s),
      .cnt_x    (cnt_x),
      .cnt_h    (cnt_h),
      .irq      (irq),
      .timeout  (timeout),
      .valid    (valid)
   );

   assign dut_vec = {irq, timeout, valid, cnt_s, cnt_x, cnt_h};

   always #5 clk_100M = ~clk_100M;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a gate is the span of cycles from its opening edge up to (not incl.) its closing edge.
   longint        t;
   bit            m_prev;
   bit            m_in_gate;
   longint        m_start, m_gl, m_last;
   bit            m_hist[$];
   logic [CW-1:0] e_s, e_x, e_h;
   bit            e_irq, e_to, e_vld;

   int g_per, g_high, g_ph;

   function automatic logic [3*CW+2:0] exp_vec();
      return {e_irq, e_to, e_vld, e_s, e_x, e_h};
   endfunction

   function automatic bit model_rise(bit s);
      return s && !m_prev;
   endfunction

   function automatic bit model_closes(bit s);
      return m_in_gate && model_rise(s) && (t - m_start >= m_gl);
   endfunction

   task automatic model_reset();
      t = 0; m_prev = 0; m_in_gate = 0; m_start = 0; m_gl = 1; m_last = -1;
      m_hist.delete();
      e_s = '0; e_x = '0; e_h = '0; e_irq = 0; e_to = 0; e_vld = 0;
   endtask

   task automatic model_cycle(bit s, bit mr, logic [CW-1:0] gl_in);
      bit rise = s && !m_prev;
      int hi = 0;
      int rises = 0;
      m_prev = s;
      e_irq = 0;
      e_to  = 0;
      if (mr) begin
         m_in_gate = 0; m_last = t; m_hist.delete();
      end else if (rise) begin
         if (m_in_gate && (t - m_start >= m_gl)) begin
            for (int i = 0; i < m_hist.size(); i++) begin
               hi += int'(m_hist[i]);
               if (i > 0) begin
                  if (m_hist[i] && !m_hist[i-1]) rises++;
               end
            end
            e_s = CW'(t - m_start); e_x = CW'(rises + 1); e_h = CW'(hi);
            e_irq = 1; e_vld = 1;
         end
         if (!m_in_gate || (t - m_start >= m_gl)) begin
            m_in_gate = 1; m_start = t; m_hist.delete();
            m_gl = (gl_in == '0) ? 1 : longint'(gl_in);
         end
         m_last = t;
      end else if (t - m_last == TO) begin
         m_in_gate = 0; m_last = t; m_hist.delete();
         e_to = 1; e_s = '0; e_x = '0; e_h = '0; e_vld = 0;
      end
      if (m_in_gate) m_hist.push_back(s);
      t++;
   endtask

   function automatic bit gen_next();
      bit s;
      if (g_per < 0) return ($urandom_range(0, 2) == 0);
      if (g_per == 0) return 1'b0;
      s = (g_ph < g_high);
      g_ph = (g_ph + 1) % g_per;
      return s;
   endfunction

   task automatic cycle(bit s);
      sig = s;
      model_cycle(s, meas_rst, gate_len);
      @(posedge clk_100M);
      #1;
   endtask

   task automatic restart(int gl, int per, int high);
      gate_len = CW'(gl); g_per = per; g_high = high; g_ph = 0;
      meas_rst = 1;
      cycle(1'b0);
      meas_rst = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; meas_rst = 0; gate_len = 100;
      repeat (3) begin sig = ~sig; @(posedge clk_100M); #1; end
      n_cmp++; if (cnt_s !== '0)   begin n_bad++; $display("FAIL reset_cnt_s got %0d want 0", cnt_s); end
      n_cmp++; if (cnt_x !== '0)   begin n_bad++; $display("FAIL reset_cnt_x got %0d want 0", cnt_x); end
      n_cmp++; if (cnt_h !== '0)   begin n_bad++; $display("FAIL reset_cnt_h got %0d want 0", cnt_h); end
      n_cmp++; if (irq !== 1'b0)     begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
      n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b want 0", timeout); end
      n_cmp++; if (valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid got %b want 0", valid); end
      sig = 0;
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_basic();
      int n_irq = 0; longint last_irq = -1; longint tt; bit s;
      restart(100, 10, 3);
      for (int i = 0; i < 400; i++) begin
         s = gen_next(); tt = t; cycle(s);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL basic_vec t=%0d got %h want %h", tt, dut_vec, exp_vec()); end
         if (irq === 1'b1) begin
            n_irq++;
            n_cmp++;
            if (cnt_s !== 100 || cnt_x !== 10 || cnt_h !== 30 || valid !== 1'b1) begin
               n_bad++; $display("FAIL basic_result got s=%0d x=%0d h=%0d v=%b want 100/10/30/1", cnt_s, cnt_x, cnt_h, valid);
            end
            if (last_irq >= 0) begin
               n_cmp++;
               if (tt - last_irq != 100) begin n_bad++; $display("FAIL basic_interval got %0d want 100", tt - last_irq); end
            end
            last_irq = tt;
         end
      end
      n_cmp++; if (n_irq != 3) begin n_bad++; $display("FAIL basic_irq_count got %0d want 3", n_irq); end
   endtask

   task automatic test_period7();
      int n_irq = 0; longint last_irq = -1; longint tt; bit s;
      restart(100, 7, 4);
      for (int i = 0; i < 330; i++) begin
         s = gen_next(); tt = t; cycle(s);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL p7_vec t=%0d got %h want %h", tt, dut_vec, exp_vec()); end
         if (irq === 1'b1) begin
            n_irq++;
            n_cmp++;
            if (cnt_s !== 105 || cnt_x !== 15 || cnt_h !== 60) begin
               n_bad++; $display("FAIL p7_result got s=%0d x=%0d h=%0d want 105/15/60", cnt_s, cnt_x, cnt_h);
            end
            if (last_irq >= 0) begin
               n_cmp++;
               if (tt - last_irq != 105) begin n_bad++; $display("FAIL p7_interval got %0d want 105", tt - last_irq); end
            end
            last_irq = tt;
         end
      end
      n_cmp++; if (n_irq != 3) begin n_bad++; $display("FAIL p7_irq_count got %0d want 3", n_irq); end
   endtask

   task automatic test_gate_zero();
      int n_irq = 0; bit s;
      restart(0, 10, 5);
      for (int i = 0; i < 60; i++) begin
         s = gen_next(); cycle(s);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL g0_vec got %h want %h", dut_vec, exp_vec()); end
         if (irq === 1'b1) begin
            n_irq++;
            n_cmp++;
            if (cnt_s !== 10 || cnt_x !== 1 || cnt_h !== 5) begin
               n_bad++; $display("FAIL g0_result got s=%0d x=%0d h=%0d want 10/1/5", cnt_s, cnt_x, cnt_h);
            end
         end
      end
      n_cmp++; if (n_irq != 5) begin n_bad++; $display("FAIL g0_irq_count got %0d want 5", n_irq); end
   endtask

   task automatic test_timeout();
      int n_to = 0; longint last_rise = -1; longint to_t = -1; longint tt; bit s;
      restart(100, 10, 3);
      for (int i = 0; i < 1300; i++) begin
         if (i == 150) g_per = 0;
         s = gen_next();
         if (model_rise(s)) last_rise = t;
         tt = t; cycle(s);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL to_vec t=%0d got %h want %h", tt, dut_vec, exp_vec()); end
         if (i == 149) begin
            n_cmp++;
            if (valid !== 1'b1) begin n_bad++; $display("FAIL to_valid_before got %b want 1", valid); end
         end
         if (timeout === 1'b1) begin
            n_to++; to_t = tt;
            n_cmp++;
            if (cnt_s !== '0 || cnt_x !== '0 || cnt_h !== '0 || valid !== 1'b0 || irq !== 1'b0) begin
               n_bad++; $display("FAIL to_clear got s=%0d x=%0d h=%0d v=%b irq=%b want all 0", cnt_s, cnt_x, cnt_h, valid, irq);
            end
         end
      end
      n_cmp++; if (n_to != 1) begin n_bad++; $display("FAIL to_count got %0d want 1", n_to); end
      n_cmp++; if (to_t - last_rise != TO) begin n_bad++; $display("FAIL to_delay got %0d want %0d", to_t - last_rise, TO); end
   endtask

   task automatic test_edge_vs_timeout();
      int n_to = 0; int to_i = -1; bit s;
      restart(5000, 0, 0);
      for (int i = 0; i <= 2 * TO + 5; i++) begin
         s = (i == 1) || (i == 1 + TO) || (i == 2 + 2 * TO);
         cycle(s);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL collide_vec i=%0d got %h want %h", i, dut_vec, exp_vec()); end
         if (timeout === 1'b1) begin n_to++; to_i = i; end
      end
      n_cmp++; if (n_to != 1) begin n_bad++; $display("FAIL collide_count got %0d want 1", n_to); end
      n_cmp++; if (to_i != 1 + 2 * TO) begin n_bad++; $display("FAIL collide_when got %0d want %0d", to_i, 1 + 2 * TO); end
   endtask

   task automatic test_meas_rst_close();
      int closes = 0; longint rise_t = -1; longint irq_t = -1; longint tt; bit s;
      restart(100, 10, 3);
      for (int i = 0; i < 400 && closes < 2; i++) begin
         s = gen_next();
         if (model_closes(s)) closes++;
         meas_rst = (closes == 2);
         cycle(s);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL mrst_vec got %h want %h", dut_vec, exp_vec()); end
      end
      meas_rst = 0;
      n_cmp++; if (closes != 2) begin n_bad++; $display("FAIL mrst_bound got %0d closes want 2", closes); end
      n_cmp++;
      if (irq !== 1'b0 || cnt_s !== 100 || cnt_x !== 10 || cnt_h !== 30 || valid !== 1'b1) begin
         n_bad++; $display("FAIL mrst_hold got irq=%b s=%0d x=%0d h=%0d v=%b want 0/100/10/30/1", irq, cnt_s, cnt_x, cnt_h, valid);
      end
      for (int i = 0; i < 250; i++) begin
         s = gen_next();
         if (rise_t < 0 && model_rise(s)) rise_t = t;
         tt = t; cycle(s);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL mrst_vec2 got %h want %h", dut_vec, exp_vec()); end
         if (irq_t < 0 && irq === 1'b1) irq_t = tt;
      end
      n_cmp++;
      if (irq_t < 0 || irq_t - rise_t != 100) begin n_bad++; $display("FAIL mrst_next_irq got %0d want 100", irq_t - rise_t); end
   endtask

   task automatic test_random();
      bit s; int len; longint tt;
      for (int r = 0; r < 8; r++) begin
         g_per = (r % 3 == 2) ? -1 : int'($urandom_range(2, 20));
         if (g_per > 0) begin
            g_high = int'($urandom_range(1, g_per - 1));
            g_ph   = int'($urandom_range(0, g_per - 1));
         end
         gate_len = CW'($urandom_range(0, 80));
         len = int'($urandom_range(200, 400));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 36) == 0) gate_len = CW'($urandom_range(0, 80));
            meas_rst = ($urandom_range(0, 149) == 0);
            s = gen_next(); tt = t; cycle(s);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rand_vec r=%0d t=%0d got %h want %h", r, tt, dut_vec, exp_vec()); end
         end
         meas_rst = 0;
      end
   endtask

   task automatic test_rst_mid_gate();
      longint rise_t = -1; longint irq_t = -1; longint tt; bit s;
      restart(100, 10, 3);
      for (int i = 0; i < 55; i++) begin
         s = gen_next(); cycle(s);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rmid_vec got %h want %h", dut_vec, exp_vec()); end
      end
      rst_n = 0;
      #1;
      n_cmp++; if (dut_vec !== '0) begin n_bad++; $display("FAIL rmid_async got %h want 0", dut_vec); end
      repeat (3) begin
         sig = gen_next(); @(posedge clk_100M); #1;
         n_cmp++; if (dut_vec !== '0) begin n_bad++; $display("FAIL rmid_held got %h want 0", dut_vec); end
      end
      gate_len = 55;
      rst_n = 1;
      model_reset();
      for (int i = 0; i < 300; i++) begin
         s = gen_next();
         if (rise_t < 0 && model_rise(s)) rise_t = t;
         tt = t; cycle(s);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rmid_vec2 got %h want %h", dut_vec, exp_vec()); end
         if (irq_t < 0 && irq === 1'b1) irq_t = tt;
      end
      n_cmp++;
      if (irq_t < 0 || irq_t - rise_t != 60) begin n_bad++; $display("FAIL rmid_first_irq got %0d want 60", irq_t - rise_t); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_period7();
      test_gate_zero();
      test_timeout();
      test_edge_vs_timeout();
      test_meas_rst_close();
      test_random();
      test_rst_mid_gate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/freq_duty_meas.md
FREQ_DUTY_MEAS -- requirements
Module: freq_duty_meas

Interface
- REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of all counters and count outputs.
- REQ-002 SHALL have parameter TIMEOUT, default 200_000_000: number of clk_100M cycles without a rising edge of sig that declares signal loss.
- REQ-003 SHALL have port clk_100M, input, 1: the only clock; all logic SHALL run on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
- REQ-005 SHALL have port meas_rst, input, 1: synchronous measurement restart.
- REQ-006 SHALL have port sig, input, 1: signal already synchronised to clk_100M.
- REQ-007 SHALL have port gate_len, input, CNT_WIDTH: minimum gate length in clk_100M cycles, sampled when a gate opens.
- REQ-008 SHALL have port cnt_s, output, CNT_WIDTH: clock cycles in the last completed gate.
- REQ-009 SHALL have port cnt_x, output, CNT_WIDTH: full sig periods in the last completed gate.
- REQ-010 SHALL have port cnt_h, output, CNT_WIDTH: clock cycles with sig high in the last completed gate.
- REQ-011 SHALL have port irq, output, 1: one-cycle pulse when new results are presented.
- REQ-012 SHALL have port timeout, output, 1: one-cycle pulse on signal loss.
- REQ-013 SHALL have port valid, output, 1: outputs hold a result from the current signal.

Function
- REQ-014 SHALL detect a rising edge in a cycle where sig=1 and the registered previous sample of sig=0.
- REQ-015 SHALL implement FSM states ARM and GATE, with ARM entered on reset.
- REQ-016 In ARM, on an edge: go to GATE, set run_s=1, run_x=0, run_h=1, and latch gl=max(gate_len,1).
- REQ-017 In GATE, in a non-closing cycle: run_s+=1, run_h+=sig, run_x+=edge.
- REQ-018 A closing cycle SHALL be an edge in GATE with run_s>=gl.
- REQ-019 On a closing cycle: register cnt_s=run_s, cnt_x=run_x+1, cnt_h=run_h.
- REQ-020 On a closing cycle: restart with run_s=1, run_x=0, run_h=1 and re-latch gl, staying in GATE (no dead time).
- REQ-021 irq SHALL be 1 in the cycle after a closing cycle, coincident with the new cnt_* values; valid SHALL be set in that same cycle.
- REQ-022 An idle counter SHALL reset to 0 on every edge and increment otherwise, in both states.
- REQ-023 When the idle counter reaches TIMEOUT-1 without an edge: go to ARM and clear run_* and the idle counter.
- REQ-024 In the following cycle after REQ-023: timeout=1, cnt_s=cnt_x=cnt_h=0, valid=0.
- REQ-025 An edge and an idle-counter expiry in the same cycle SHALL resolve as an edge: no timeout.
- REQ-026 meas_rst=1 SHALL force ARM and clear run_* and the idle counter.
- REQ-027 meas_rst=1 SHALL suppress irq and timeout for that cycle and retain cnt_*/valid.
- REQ-028 meas_rst SHALL win over a simultaneous closing edge or timeout.
- REQ-029 With TIMEOUT+max(gate_len) < 2^CNT_WIDTH, run_s SHALL never wrap; run_x and run_h are bounded by run_s.
- REQ-030 gate_len changes SHALL affect only the next gate opened.
- REQ-031 Latency: results SHALL appear 1 cycle after the closing edge is detected (2 cycles after the sig transition at the module input).

Reset
- REQ-032 While rst_n=0, cnt_s, cnt_x, cnt_h, irq, timeout, valid and all internal counters SHALL be 0, with FSM=ARM and edge history=0.
- REQ-033 After rst_n deasserts mid-gate, the first irq SHALL require a fresh opening edge plus a full gate.

Verification
- REQ-034 sig period 10 cycles, 3 high, gate_len=100 -> irq every 100 cycles; cnt_s=100, cnt_x=10, cnt_h=30, valid=1.
- REQ-035 sig period 7, gate_len=100 -> cnt_s=105, cnt_x=15; irq interval 105 cycles.
- REQ-036 gate_len=0, period 10 -> irq on every period; cnt_s=10, cnt_x=1.
- REQ-037 TIMEOUT=1000, sig stops after a valid result -> timeout pulse 1000 cycles after the last edge; cnt_*=0, valid=0, no irq.
- REQ-038 meas_rst on a closing-edge cycle -> no irq, cnt_* unchanged; next irq 100 cycles after the first edge following meas_rst (period 10, gate_len=100).
- REQ-039 rst_n pulse mid-gate -> all outputs 0 during reset; first irq gate_len cycles after the first post-reset edge (rounded up to the next edge).
